// File: rtl/ws2812_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ws2812_serializer_if                                        |
// | Brief  : fader-to-serializer byte handshake (trigger/request/color)  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface ws2812_serializer_if;
  logic       trigger;
  logic [7:0] color_in;
  logic       data_request;

  modport master (output trigger, output color_in, input data_request);
  modport slave  (input trigger, input color_in, output data_request);
endinterface
`default_nettype wire

// File: rtl/ws2812_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ws2812_serializer                                           |
// | Brief  : pulls bytes from the fader and drives one WS2812 NRZ line,  |
// |          MSB first, closing each frame with a low latch gap.         |
// |          Optional: WS2812_TRIGGER_PENDING_EN queues one frame.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ws2812_serializer #(
  parameter int LED_COUNT    = 8,
  parameter int T0H          = 4,
  parameter int T1H          = 10,
  parameter int TBIT         = 15,
  parameter int RESET_CYCLES = 720,
  parameter int REQ_LATENCY  = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ws2812_serializer_if.slave src,
  output logic               ws_out,
  output logic               busy,
  output logic               frame_done
);

  localparam int NBYTES = LED_COUNT * 3;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CYC_W  = $clog2(TBIT);
  localparam int LAT_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic [CYC_W-1:0]  cyc_q,      cyc_d;
  logic [2:0]        bit_idx_q,  bit_idx_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LAT_W-1:0]  latch_q,    latch_d;
  logic [7:0]        shift_q,    shift_d;
  logic [7:0]        next_q,     next_d;
  logic              ws_out_q,   ws_out_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              req_q,      req_d;

  logic bit_end, fetch_done, last_byte, latch_end, restart;

  assign bit_end    = (cyc_q == CYC_W'(TBIT - 1));
  assign fetch_done = (cyc_q == CYC_W'(REQ_LATENCY));
  assign last_byte  = (byte_cnt_q == BYTE_W'(NBYTES - 1));
  assign latch_end  = (latch_q == LAT_W'(RESET_CYCLES - 1));

`ifdef WS2812_TRIGGER_PENDING_EN
  logic pend_q, pend_d;

  // A trigger on the final latch cycle counts as well, so it is never lost.
  always_comb begin
    pend_d = pend_q;
    if (src.trigger && (state_q != S_IDLE)) pend_d = 1'b1;
    if ((state_q == S_LATCH) && (state_d == S_FETCH)) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

  assign restart = pend_q | src.trigger;
`else
  assign restart = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      latch_q    <= '0;
      shift_q    <= '0;
      next_q     <= '0;
      ws_out_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      latch_q    <= latch_d;
      shift_q    <= shift_d;
      next_q     <= next_d;
      ws_out_q   <= ws_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      req_q      <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (src.trigger) state_d = S_FETCH;
      S_FETCH: if (fetch_done) state_d = S_SHIFT;
      S_SHIFT: if (bit_end && (bit_idx_q == 3'd0) && last_byte) state_d = S_LATCH;
      S_LATCH: if (latch_end) state_d = restart ? S_FETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cyc_d      = cyc_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    latch_d    = latch_q;
    shift_d    = shift_q;
    next_d     = next_q;
    case (state_q)
      S_FETCH: begin
        cyc_d = cyc_q + 1'b1;
        if (fetch_done) begin
          shift_d   = src.color_in;
          bit_idx_d = 3'd7;
          cyc_d     = '0;
        end
      end
      S_SHIFT: begin
        cyc_d = cyc_q + 1'b1;
        // Prefetched byte arrives while the current byte's LSB is on the line.
        if ((bit_idx_q == 3'd0) && !last_byte && fetch_done) next_d = src.color_in;
        if (bit_end) begin
          cyc_d = '0;
          if (bit_idx_q == 3'd0) begin
            shift_d   = next_q;
            bit_idx_d = 3'd7;
            if (!last_byte) byte_cnt_d = byte_cnt_q + 1'b1;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_idx_d = bit_idx_q - 3'd1;
          end
        end
      end
      S_LATCH: latch_d = latch_q + 1'b1;
      default: ;
    endcase
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
      cyc_d      = '0;
      byte_cnt_d = '0;
    end
    if ((state_d == S_LATCH) && (state_q != S_LATCH)) latch_d = '0;
  end

  // Outputs are registered from next-state values so the line is glitch-free.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    req_d    = ((state_d == S_FETCH) && (cyc_d == '0)) ||
               ((state_d == S_SHIFT) && (bit_idx_d == 3'd0) && (cyc_d == '0) &&
                (byte_cnt_d != BYTE_W'(NBYTES - 1)));
    ws_out_d = (state_d == S_SHIFT) &&
               (cyc_d < (shift_d[7] ? CYC_W'(T1H) : CYC_W'(T0H)));
    done_d   = (state_d == S_LATCH) && (latch_d == LAT_W'(RESET_CYCLES - 1));
  end

  assign src.data_request = req_q;
  assign ws_out           = ws_out_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ws2812_serializer                                        |
// | Brief  : directed bench, 1 LED frame of A5/00/FF from a model source |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_ws2812_serializer;

`ifdef WS2812_TRIGGER_PENDING_EN
  localparam int RESTART_GAP = 1;
`else
  localparam int RESTART_GAP = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ws_out, busy, frame_done;

  ws2812_serializer_if u_if ();

  ws2812_serializer #(
    .LED_COUNT(1), .T0H(4), .T1H(10), .TBIT(15), .RESET_CYCLES(720), .REQ_LATENCY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src(u_if.slave),
    .ws_out(ws_out), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int exp_hi [24] = '{10, 4, 10, 4, 4, 10, 4, 10,
                      4, 4, 4, 4, 4, 4, 4, 4,
                      10, 10, 10, 10, 10, 10, 10, 10};
  logic [7:0] src_bytes [3] = '{8'hA5, 8'h00, 8'hFF};

  // Line monitor and byte source; sole writer of everything below.
  int   cyc_n = 0, hi_len = 0, fd_cnt = 0, fd_cyc = -1;
  int   busy_fall = -1, busy_rise = -1, src_idx = 0;
  logic ws_prev = 1'b0, busy_prev = 1'b0, req_dly = 1'b0;
  int   rise_q[$], hi_q[$], req_q[$];

  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (ws_out && !ws_prev) rise_q.push_back(cyc_n);
    if (ws_out) hi_len = hi_len + 1;
    else if (ws_prev) begin
      hi_q.push_back(hi_len);
      hi_len = 0;
    end
    ws_prev = ws_out;
    if (!rst_n) begin
      src_idx = 0;
      req_dly = 1'b0;
    end else begin
      if (req_dly) begin
        u_if.color_in = src_bytes[src_idx];
        src_idx = (src_idx == 2) ? 0 : src_idx + 1;
      end
      req_dly = u_if.data_request;
    end
    if (u_if.data_request) req_q.push_back(cyc_n);
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc_n;
    end
    if (busy && !busy_prev) busy_rise = cyc_n;
    if (!busy && busy_prev) busy_fall = cyc_n;
    busy_prev = busy;
  end

  task automatic test_reset();
    int bad_ws = 0, bad_busy = 0, bad_req = 0, bad_fd = 0;
    u_if.trigger = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ws_out, busy, u_if.data_request, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_reset: outputs %b, expected 0000",
               {ws_out, busy, u_if.data_request, frame_done});
    end
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (ws_out !== 1'b0) bad_ws++;
      if (busy !== 1'b0) bad_busy++;
      if (u_if.data_request !== 1'b0) bad_req++;
      if (frame_done !== 1'b0) bad_fd++;
    end
    checks++; if (bad_ws != 0)   begin errors++; $display("FAIL reset_ws_out: %0d high cycles, expected 0", bad_ws); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL reset_busy: %0d high cycles, expected 0", bad_busy); end
    checks++; if (bad_req != 0)  begin errors++; $display("FAIL reset_request: %0d high cycles, expected 0", bad_req); end
    checks++; if (bad_fd != 0)   begin errors++; $display("FAIL reset_frame_done: %0d high cycles, expected 0", bad_fd); end
  endtask

  task automatic test_frame();
    int rb, hb, qb, fb, t0, nr, nh, nq, last_rise;
    @(posedge clk); #1;
    rb = rise_q.size(); hb = hi_q.size(); qb = req_q.size(); fb = fd_cnt;
    t0 = cyc_n + 1;
    u_if.trigger = 1'b1;
    @(posedge clk); #1;
    u_if.trigger = 1'b0;
    for (int i = 0; i < 2000 && fd_cnt == fb; i++) begin
      @(posedge clk); #2;
    end
    checks++;
    if (fd_cnt == fb) begin
      errors++;
      $display("FAIL frame_timeout: no frame_done within 2000 cycles");
      return;
    end
    repeat (5) @(posedge clk);
    #1;
    nr = rise_q.size() - rb; nh = hi_q.size() - hb; nq = req_q.size() - qb;
    checks++; if (nh != 24) begin errors++; $display("FAIL frame_bit_count: %0d pulses, expected 24", nh); end
    checks++; if (nr != 24) begin errors++; $display("FAIL frame_rise_count: %0d rises, expected 24", nr); end
    for (int k = 0; k < 24 && k < nh; k++) begin
      checks++;
      if (hi_q[hb + k] != exp_hi[k]) begin
        errors++;
        $display("FAIL frame_high_time bit %0d: %0d cycles, expected %0d", k, hi_q[hb + k], exp_hi[k]);
      end
    end
    for (int k = 1; k < 24 && k < nr; k++) begin
      checks++;
      if (rise_q[rb + k] - rise_q[rb + k - 1] != 15) begin
        errors++;
        $display("FAIL frame_bit_period bit %0d: %0d cycles, expected 15", k, rise_q[rb + k] - rise_q[rb + k - 1]);
      end
    end
    checks++;
    if (nr < 1 || rise_q[rb] != t0 + 3) begin
      errors++;
      $display("FAIL frame_first_rise: cycle %0d, expected %0d", (nr < 1) ? -1 : rise_q[rb], t0 + 3);
    end
    checks++; if (busy_rise != t0 + 1) begin errors++; $display("FAIL frame_busy_rise: cycle %0d, expected %0d", busy_rise, t0 + 1); end
    checks++; if (nq != 3) begin errors++; $display("FAIL frame_request_count: %0d, expected 3", nq); end
    if (nq == 3) begin
      checks++; if (req_q[qb] != t0 + 1)       begin errors++; $display("FAIL frame_req0_cycle: %0d, expected %0d", req_q[qb], t0 + 1); end
      checks++; if (req_q[qb + 1] != t0 + 108) begin errors++; $display("FAIL frame_req1_cycle: %0d, expected %0d", req_q[qb + 1], t0 + 108); end
      checks++; if (req_q[qb + 2] != t0 + 228) begin errors++; $display("FAIL frame_req2_cycle: %0d, expected %0d", req_q[qb + 2], t0 + 228); end
    end
    checks++; if (fd_cnt - fb != 1) begin errors++; $display("FAIL frame_done_count: %0d, expected 1", fd_cnt - fb); end
    last_rise = (nr >= 24) ? rise_q[rb + 23] : t0 + 348;
    checks++; if (fd_cyc != last_rise + 15 + 719) begin errors++; $display("FAIL frame_done_cycle: %0d, expected %0d", fd_cyc, last_rise + 734); end
    checks++; if (fd_cyc != t0 + 1082) begin errors++; $display("FAIL frame_total_length: done at %0d, expected %0d", fd_cyc, t0 + 1082); end
    checks++; if (busy_fall != fd_cyc + 1) begin errors++; $display("FAIL frame_busy_fall: cycle %0d, expected %0d", busy_fall, fd_cyc + 1); end
  endtask

  task automatic test_reset_mid_frame();
    int rb, hb, qb, fb, nh, found;
    @(posedge clk); #1;
    rb = rise_q.size();
    u_if.trigger = 1'b1;
    @(posedge clk); #1;
    u_if.trigger = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk); #1;
      if (rise_q.size() - rb == 11 && ws_out === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL midrst_bit10: bit 10 high phase not reached");
      return;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (ws_out !== 1'b0) begin errors++; $display("FAIL midrst_ws_async: ws_out %b, expected 0", ws_out); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy: busy %b, expected 0", busy); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || ws_out !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy %b ws_out %b, expected 0 0", busy, ws_out); end
    hb = hi_q.size(); qb = req_q.size(); fb = fd_cnt;
    u_if.trigger = 1'b1;
    @(posedge clk); #1;
    u_if.trigger = 1'b0;
    for (int i = 0; i < 2000 && fd_cnt == fb; i++) begin
      @(posedge clk); #2;
    end
    checks++;
    if (fd_cnt == fb) begin
      errors++;
      $display("FAIL midrst_timeout: no frame_done within 2000 cycles");
      return;
    end
    repeat (3) @(posedge clk);
    #1;
    nh = hi_q.size() - hb;
    checks++; if (nh != 24) begin errors++; $display("FAIL midrst_bit_count: %0d pulses, expected 24", nh); end
    for (int k = 0; k < 24 && k < nh; k++) begin
      checks++;
      if (hi_q[hb + k] != exp_hi[k]) begin
        errors++;
        $display("FAIL midrst_high_time bit %0d: %0d cycles, expected %0d", k, hi_q[hb + k], exp_hi[k]);
      end
    end
    checks++; if (req_q.size() - qb != 3) begin errors++; $display("FAIL midrst_request_count: %0d, expected 3", req_q.size() - qb); end
  endtask

  task automatic wait_idle(input string tag);
    int ok = 0;
    for (int i = 0; i < 4000 && ok == 0; i++) begin
      @(posedge clk); #2;
      if (busy === 1'b0) ok = 1;
    end
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy still %b after 4000 cycles", tag, busy);
    end
  endtask

  task automatic test_back_to_back();
    int qb, fb, f1, hit;
    @(posedge clk); #1;
    qb = req_q.size(); fb = fd_cnt;
    u_if.trigger = 1'b1;
    for (int i = 0; i < 2000 && fd_cnt == fb; i++) begin
      @(posedge clk); #2;
    end
    checks++;
    if (fd_cnt == fb) begin
      errors++;
      $display("FAIL b2b_timeout: no frame_done within 2000 cycles");
      u_if.trigger = 1'b0;
      return;
    end
    f1 = fd_cyc;
    repeat (4) @(posedge clk);
    #1 u_if.trigger = 1'b0;
    hit = -1;
    for (int k = qb; k < req_q.size(); k++) if (hit < 0 && req_q[k] > f1) hit = req_q[k];
    checks++;
    if (hit != f1 + RESTART_GAP) begin
      errors++;
      $display("FAIL b2b_restart: next request at %0d, expected %0d", hit, f1 + RESTART_GAP);
    end
`ifndef WS2812_TRIGGER_PENDING_EN
    checks++; if (busy_fall != f1 + 1) begin errors++; $display("FAIL b2b_idle_gap: busy fell at %0d, expected %0d", busy_fall, f1 + 1); end
`endif
    wait_idle("b2b");
  endtask

  task automatic test_trigger_while_busy();
    int rb, qb, fb, f1, hit, found;
    @(posedge clk); #1;
    rb = rise_q.size(); qb = req_q.size(); fb = fd_cnt;
    u_if.trigger = 1'b1;
    @(posedge clk); #1;
    u_if.trigger = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(posedge clk); #2;
      if (rise_q.size() - rb >= 12) found = 1;
    end
    @(posedge clk); #1;
    u_if.trigger = 1'b1;
    @(posedge clk); #1;
    u_if.trigger = 1'b0;
    for (int i = 0; i < 2000 && fd_cnt == fb; i++) begin
      @(posedge clk); #2;
    end
    checks++;
    if (found == 0 || fd_cnt == fb) begin
      errors++;
      $display("FAIL busytrig_timeout: byte 1 reached %0d, frame_done seen %0d", found, fd_cnt - fb);
      return;
    end
    f1 = fd_cyc;
    repeat (30) @(posedge clk);
    #1;
    hit = -1;
    for (int k = qb; k < req_q.size(); k++) if (hit < 0 && req_q[k] > f1) hit = req_q[k];
`ifdef WS2812_TRIGGER_PENDING_EN
    checks++; if (hit != f1 + 1) begin errors++; $display("FAIL busytrig_queued: next request at %0d, expected %0d", hit, f1 + 1); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busytrig_busy: busy %b, expected 1", busy); end
`else
    checks++; if (hit != -1) begin errors++; $display("FAIL busytrig_lost: request at %0d, expected none", hit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busytrig_busy: busy %b, expected 0", busy); end
`endif
    wait_idle("busytrig");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_reset_mid_frame();
    test_back_to_back();
    test_trigger_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
